// File: rtl/dvi_seq_pkg.sv
// +----------------------------------------------------------------------+
// | Module      : dvi_seq_pkg                                            |
// | Description : Shared types and sizes for the DVI output sequencer.   |
// |               Holds the FSM state encoding (also the o_state value), |
// |               the default source-select width and the lock-loss      |
// |               counter width.                                         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

package dvi_seq_pkg;

  // Encoding is visible on o_state, so values are fixed.
  typedef enum logic [2:0] {
    ST_HOLD   = 3'd0,
    ST_WARMUP = 3'd1,
    ST_RUN    = 3'd2,
    ST_SWITCH = 3'd3
  } state_t;

  localparam int DEF_SRC_W  = 2;
  localparam int LOCK_CNT_W = 8;

endpackage

`default_nettype wire

// File: rtl/sync_2ff.sv
// +----------------------------------------------------------------------+
// | Module      : sync_2ff                                               |
// | Description : Two-flop synchroniser for a single asynchronous level. |
// | Ports       : i_clk  - destination clock                             |
// |               i_rst  - synchronous active-high reset (output to 0)   |
// |               i_d    - asynchronous input                            |
// |               o_q    - synchronised output, 2 cycles of latency      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module sync_2ff (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [1:0] r_sync;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync <= 2'b00;
    end else begin
      r_sync <= {r_sync[0], i_d};
    end
  end

  assign o_q = r_sync[1];

endmodule

`default_nettype wire

// File: rtl/dvi_output_seq.sv
// +----------------------------------------------------------------------+
// | Module      : dvi_output_seq                                         |
// | Description : Bring-up and source-switch sequencer for the DVI path. |
// |               Holds the timing generator in reset until PLL lock is  |
// |               stable, blanks video for a warm-up period, switches    |
// |               sources at frame boundaries with a req/ack handshake   |
// |               and registers the gated RGB/sync stream.               |
// | Ports       : i_pix_clk/i_rst      - clock, sync active-high reset   |
// |               i_pll_locked         - raw async PLL lock              |
// |               i_frame,i_hs,i_vs,i_de - timing generator outputs      |
// |               i_red/green/blue     - pixel from active source        |
// |               i_src_req/i_src_sel  - source change request           |
// |               o_src_ack/o_src_sel  - ack pulse, source mux select    |
// |               o_timing_rst         - timing generator reset          |
// |               o_video_en           - video unblanked                 |
// |               o_hs/vs/de, o_red/green/blue - registered encoder feed |
// |               o_state              - FSM state                       |
// |               o_lock_lost_cnt      - saturating lock-loss count      |
// | Config      : DVI_SEQ_LOCK_CNT_EN - builds the lock-loss counter;    |
// |               when undefined o_lock_lost_cnt is tied to 0.           |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module dvi_output_seq
  import dvi_seq_pkg::*;
#(
  parameter int   LOCK_STABLE_CYCLES = 1024,
  parameter int   WARMUP_FRAMES      = 2,
  parameter int   BLANK_FRAMES       = 1,
  parameter int   SRC_W              = DEF_SRC_W,
  parameter int   DEFAULT_SRC        = 0,
  parameter logic H_POL              = 1'b0,
  parameter logic V_POL              = 1'b0
) (
  input  logic                  i_pix_clk,
  input  logic                  i_rst,
  input  logic                  i_pll_locked,
  input  logic                  i_frame,
  input  logic                  i_hs,
  input  logic                  i_vs,
  input  logic                  i_de,
  input  logic [7:0]            i_red,
  input  logic [7:0]            i_green,
  input  logic [7:0]            i_blue,
  input  logic                  i_src_req,
  input  logic [SRC_W-1:0]      i_src_sel,
  output logic                  o_src_ack,
  output logic [SRC_W-1:0]      o_src_sel,
  output logic                  o_timing_rst,
  output logic                  o_video_en,
  output logic                  o_hs,
  output logic                  o_vs,
  output logic                  o_de,
  output logic [7:0]            o_red,
  output logic [7:0]            o_green,
  output logic [7:0]            o_blue,
  output logic [2:0]            o_state,
  output logic [LOCK_CNT_W-1:0] o_lock_lost_cnt
);

  localparam int c_stable_w  = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int c_frame_max = (WARMUP_FRAMES > BLANK_FRAMES) ? WARMUP_FRAMES : BLANK_FRAMES;
  localparam int c_frame_w   = (c_frame_max < 2) ? 1 : $clog2(c_frame_max + 1);

  logic w_lock_s;

  sync_2ff u_lock_sync (
    .i_clk (i_pix_clk),
    .i_rst (i_rst),
    .i_d   (i_pll_locked),
    .o_q   (w_lock_s)
  );

  state_t                r_state;
  state_t                w_state_next;
  logic [c_stable_w-1:0] r_stable_cnt;
  logic [c_frame_w-1:0]  r_frame_cnt;
  logic                  r_pend;
  logic [SRC_W-1:0]      r_pending;
  logic [SRC_W-1:0]      r_src_sel;
  logic                  r_src_ack;
  logic                  r_timing_rst;
  logic                  r_video_en;
  logic                  r_hs, r_vs, r_de;
  logic [7:0]            r_red, r_green, r_blue;

  logic w_lock_loss, w_stable_done, w_warm_done, w_blank_done;
  logic w_en_next, w_trst_next;

  always_comb begin
    w_lock_loss   = (r_state != ST_HOLD) && !w_lock_s;
    // Lock must still be present on the releasing cycle, otherwise we
    // would leave HOLD only to count a lock loss one cycle later.
    w_stable_done = (r_stable_cnt == c_stable_w'(LOCK_STABLE_CYCLES)) && w_lock_s;
    w_warm_done   = i_frame && (r_frame_cnt == c_frame_w'(WARMUP_FRAMES - 1));
    w_blank_done  = i_frame && (r_frame_cnt == c_frame_w'(BLANK_FRAMES - 1));

    w_state_next = r_state;
    if (w_lock_loss) begin
      w_state_next = ST_HOLD;
    end else begin
      case (r_state)
        ST_HOLD:   if (w_stable_done)       w_state_next = ST_WARMUP;
        ST_WARMUP: if (w_warm_done)         w_state_next = ST_RUN;
        ST_RUN:    if (i_frame && r_pend)   w_state_next = ST_SWITCH;
        ST_SWITCH: if (w_blank_done)        w_state_next = ST_RUN;
        default:                            w_state_next = ST_HOLD;
      endcase
    end

    // Gating follows the next state so it flips on the frame-start pixel.
    w_en_next   = (w_state_next == ST_RUN);
    w_trst_next = (w_state_next == ST_HOLD);
  end

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      r_state      <= ST_HOLD;
      r_stable_cnt <= '0;
      r_frame_cnt  <= '0;
      r_pend       <= 1'b0;
      r_pending    <= SRC_W'(DEFAULT_SRC);
      r_src_sel    <= SRC_W'(DEFAULT_SRC);
      r_src_ack    <= 1'b0;
      r_timing_rst <= 1'b1;
      r_video_en   <= 1'b0;
      r_hs         <= ~H_POL;
      r_vs         <= ~V_POL;
      r_de         <= 1'b0;
      r_red        <= '0;
      r_green      <= '0;
      r_blue       <= '0;
    end else begin
      r_state      <= w_state_next;
      r_timing_rst <= w_trst_next;
      r_video_en   <= w_en_next;
      r_src_ack    <= 1'b0;

      if ((r_state == ST_HOLD) && w_lock_s && !w_stable_done) begin
        r_stable_cnt <= r_stable_cnt + 1'b1;
      end else begin
        r_stable_cnt <= '0;
      end

      if (w_state_next != r_state) begin
        r_frame_cnt <= '0;
      end else if (i_frame && ((r_state == ST_WARMUP) || (r_state == ST_SWITCH))) begin
        r_frame_cnt <= r_frame_cnt + 1'b1;
      end

      // Lock loss takes priority over the ack; the requester keeps its
      // request up, so it is picked up again once RUN is re-entered.
      // The ack cycle itself is excluded from sampling because the
      // requester is still holding the old request during it.
      if (w_lock_loss) begin
        r_pend <= 1'b0;
      end else if ((r_state == ST_SWITCH) && w_blank_done) begin
        r_pend    <= 1'b0;
        r_src_ack <= 1'b1;
      end else if ((r_state == ST_RUN) && !r_pend && !r_src_ack && i_src_req) begin
        r_pend    <= 1'b1;
        r_pending <= i_src_sel;
      end

      if ((r_state == ST_RUN) && (w_state_next == ST_SWITCH)) begin
        r_src_sel <= r_pending;
      end

      r_hs    <= w_trst_next ? ~H_POL : i_hs;
      r_vs    <= w_trst_next ? ~V_POL : i_vs;
      r_de    <= w_trst_next ? 1'b0   : i_de;
      r_red   <= (w_en_next && i_de) ? i_red   : 8'd0;
      r_green <= (w_en_next && i_de) ? i_green : 8'd0;
      r_blue  <= (w_en_next && i_de) ? i_blue  : 8'd0;
    end
  end

`ifdef DVI_SEQ_LOCK_CNT_EN
  logic [LOCK_CNT_W-1:0] r_lock_lost_cnt;

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      r_lock_lost_cnt <= '0;
    end else if (w_lock_loss && (r_lock_lost_cnt != {LOCK_CNT_W{1'b1}})) begin
      r_lock_lost_cnt <= r_lock_lost_cnt + 1'b1;
    end
  end

  assign o_lock_lost_cnt = r_lock_lost_cnt;
`else
  assign o_lock_lost_cnt = '0;
`endif

  assign o_state      = r_state;
  assign o_src_ack    = r_src_ack;
  assign o_src_sel    = r_src_sel;
  assign o_timing_rst = r_timing_rst;
  assign o_video_en   = r_video_en;
  assign o_hs         = r_hs;
  assign o_vs         = r_vs;
  assign o_de         = r_de;
  assign o_red        = r_red;
  assign o_green      = r_green;
  assign o_blue       = r_blue;

endmodule

`default_nettype wire

// File: tb/tb_dvi_output_seq.sv
// +----------------------------------------------------------------------+
// | Module      : tb_dvi_output_seq                                      |
// | Description : Directed self-checking bench for dvi_output_seq.       |
// |               Pixel-path expectations go through a scoreboard queue. |
// |               DVI_SEQ_LOCK_CNT_EN selects the expected counter value.|
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_dvi_output_seq;

`ifdef DVI_SEQ_LOCK_CNT_EN
  localparam bit c_cnt_en = 1'b1;
`else
  localparam bit c_cnt_en = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       i_rst, i_pll_locked, i_frame, i_hs, i_vs, i_de, i_src_req;
  logic [7:0] i_red, i_green, i_blue;
  logic [1:0] i_src_sel;

  logic       o_src_ack, o_timing_rst, o_video_en, o_hs, o_vs, o_de;
  logic [1:0] o_src_sel;
  logic [7:0] o_red, o_green, o_blue, o_lock_lost_cnt;
  logic [2:0] o_state;

  logic       d2_src_ack, d2_timing_rst, d2_video_en, d2_hs, d2_vs, d2_de;
  logic [1:0] d2_src_sel;
  logic [7:0] d2_red, d2_green, d2_blue, d2_lock_lost_cnt;
  logic [2:0] d2_state;

  int n_total = 0;
  int n_bad   = 0;

  typedef struct packed {
    logic        hs;
    logic        vs;
    logic        de;
    logic [23:0] rgb;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  dvi_output_seq #(
    .LOCK_STABLE_CYCLES(16), .WARMUP_FRAMES(2), .BLANK_FRAMES(1),
    .SRC_W(2), .DEFAULT_SRC(0), .H_POL(1'b0), .V_POL(1'b0)
  ) dut (
    .i_pix_clk(clk), .i_rst(i_rst), .i_pll_locked(i_pll_locked),
    .i_frame(i_frame), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
    .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .i_src_req(i_src_req), .i_src_sel(i_src_sel),
    .o_src_ack(o_src_ack), .o_src_sel(o_src_sel),
    .o_timing_rst(o_timing_rst), .o_video_en(o_video_en),
    .o_hs(o_hs), .o_vs(o_vs), .o_de(o_de),
    .o_red(o_red), .o_green(o_green), .o_blue(o_blue),
    .o_state(o_state), .o_lock_lost_cnt(o_lock_lost_cnt)
  );

  dvi_output_seq #(
    .LOCK_STABLE_CYCLES(16), .WARMUP_FRAMES(2), .BLANK_FRAMES(1),
    .SRC_W(2), .DEFAULT_SRC(0), .H_POL(1'b1), .V_POL(1'b1)
  ) dut_pol (
    .i_pix_clk(clk), .i_rst(i_rst), .i_pll_locked(i_pll_locked),
    .i_frame(i_frame), .i_hs(i_hs), .i_vs(i_vs), .i_de(i_de),
    .i_red(i_red), .i_green(i_green), .i_blue(i_blue),
    .i_src_req(i_src_req), .i_src_sel(i_src_sel),
    .o_src_ack(d2_src_ack), .o_src_sel(d2_src_sel),
    .o_timing_rst(d2_timing_rst), .o_video_en(d2_video_en),
    .o_hs(d2_hs), .o_vs(d2_vs), .o_de(d2_de),
    .o_red(d2_red), .o_green(d2_green), .o_blue(d2_blue),
    .o_state(d2_state), .o_lock_lost_cnt(d2_lock_lost_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One pixel cycle: expected output is pushed when the pixel is driven
  // and popped once the registered output is visible.
  task automatic step(input logic fr, input logic de, input logic en,
                      input logic trst, input string tag);
    exp_t        e;
    logic [23:0] rgb;
    rgb = 24'($urandom) | 24'h010101;
    i_frame = fr;
    i_de    = de;
    {i_red, i_green, i_blue} = rgb;
    i_hs = rgb[3];
    i_vs = rgb[7];
    e.rgb = (en && de) ? rgb : 24'd0;
    e.de  = trst ? 1'b0 : de;
    e.hs  = trst ? 1'b1 : rgb[3];
    e.vs  = trst ? 1'b1 : rgb[7];
    sb.push_back(e);
    tick();
    i_frame = 1'b0;
    e = sb.pop_front();
    chk({tag, ":rgb"}, {8'd0, o_red, o_green, o_blue}, {8'd0, e.rgb});
    chk({tag, ":de"},  {31'd0, o_de}, {31'd0, e.de});
    chk({tag, ":hs"},  {31'd0, o_hs}, {31'd0, e.hs});
    chk({tag, ":vs"},  {31'd0, o_vs}, {31'd0, e.vs});
  endtask

  initial begin
    // ---------------- reset state ----------------
    i_rst = 1'b1; i_pll_locked = 1'b0; i_frame = 1'b0;
    i_hs = 1'b0; i_vs = 1'b0; i_de = 1'b1;
    i_red = 8'hAA; i_green = 8'h55; i_blue = 8'h33;
    i_src_req = 1'b0; i_src_sel = 2'd0;
    repeat (3) tick();
    chk("rst_state", 32'(o_state), 32'd0);
    chk("rst_trst",  32'(o_timing_rst), 32'd1);
    chk("rst_en",    32'(o_video_en), 32'd0);
    chk("rst_ack",   32'(o_src_ack), 32'd0);
    chk("rst_sel",   32'(o_src_sel), 32'd0);
    chk("rst_hs",    32'(o_hs), 32'd1);
    chk("rst_vs",    32'(o_vs), 32'd1);
    chk("rst_de",    32'(o_de), 32'd0);
    chk("rst_rgb",   {8'd0, o_red, o_green, o_blue}, 32'd0);
    chk("rst_cnt",   32'(o_lock_lost_cnt), 32'd0);
    i_hs = 1'b1; i_vs = 1'b1;
    tick();
    chk("pol_hs",  32'(d2_hs), 32'd0);
    chk("pol_vs",  32'(d2_vs), 32'd0);
    chk("pol_de",  32'(d2_de), 32'd0);
    chk("pol_rgb", {8'd0, d2_red, d2_green, d2_blue}, 32'd0);

    // ---------------- lock glitch in HOLD, then bring-up ----------------
    i_rst = 1'b0; i_de = 1'b0; i_hs = 1'b0; i_vs = 1'b0;
    i_pll_locked = 1'b1;
    repeat (12) tick();
    i_pll_locked = 1'b0;
    tick();
    i_pll_locked = 1'b1;
    repeat (18) tick();
    chk("glitch_trst_hi", 32'(o_timing_rst), 32'd1);
    chk("glitch_state",   32'(o_state), 32'd0);
    tick();
    chk("bringup_trst_lo", 32'(o_timing_rst), 32'd0);
    chk("bringup_state",   32'(o_state), 32'd1);
    chk("glitch_cnt",      32'(o_lock_lost_cnt), 32'd0);

    // ---------------- warm-up ----------------
    step(1'b0, 1'b1, 1'b0, 1'b0, "warm_pre0");
    step(1'b0, 1'b1, 1'b0, 1'b0, "warm_pre1");
    step(1'b1, 1'b1, 1'b0, 1'b0, "warm_f1");
    step(1'b0, 1'b1, 1'b0, 1'b0, "warm_mid");
    step(1'b1, 1'b1, 1'b1, 1'b0, "warm_f2");
    step(1'b0, 1'b1, 1'b1, 1'b0, "run_px");
    step(1'b0, 1'b0, 1'b1, 1'b0, "run_de_low");
    chk("run_state", 32'(o_state), 32'd2);
    chk("run_en",    32'(o_video_en), 32'd1);

    // ---------------- source switch ----------------
    i_src_req = 1'b1; i_src_sel = 2'd2;
    step(1'b0, 1'b1, 1'b1, 1'b0, "req0");
    step(1'b0, 1'b1, 1'b1, 1'b0, "req1");
    chk("pre_sel", 32'(o_src_sel), 32'd0);
    chk("pre_ack", 32'(o_src_ack), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, "sw_frame");
    chk("sw_sel",   32'(o_src_sel), 32'd2);
    chk("sw_state", 32'(o_state), 32'd3);
    step(1'b0, 1'b1, 1'b0, 1'b0, "sw_blank0");
    step(1'b0, 1'b1, 1'b0, 1'b0, "sw_blank1");
    step(1'b1, 1'b1, 1'b1, 1'b0, "sw_end");
    chk("sw_ack",      32'(o_src_ack), 32'd1);
    chk("sw_back_run", 32'(o_state), 32'd2);
    i_src_req = 1'b0;
    step(1'b0, 1'b1, 1'b1, 1'b0, "post_ack");
    chk("ack_once", 32'(o_src_ack), 32'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, "run_nopend");
    chk("nopend_state", 32'(o_state), 32'd2);

    // ---------------- lock loss on the ack frame ----------------
    i_src_req = 1'b1; i_src_sel = 2'd1;
    step(1'b0, 1'b1, 1'b1, 1'b0, "ll_req");
    step(1'b1, 1'b1, 1'b0, 1'b0, "ll_sw");
    chk("ll_sw_sel",   32'(o_src_sel), 32'd1);
    chk("ll_sw_state", 32'(o_state), 32'd3);
    i_pll_locked = 1'b0;
    step(1'b0, 1'b1, 1'b0, 1'b0, "ll_a");
    step(1'b0, 1'b1, 1'b0, 1'b0, "ll_b");
    step(1'b1, 1'b1, 1'b0, 1'b1, "ll_frame");
    chk("ll_no_ack", 32'(o_src_ack), 32'd0);
    chk("ll_state",  32'(o_state), 32'd0);
    chk("ll_trst",   32'(o_timing_rst), 32'd1);
    chk("ll_cnt",    32'(o_lock_lost_cnt), 32'(c_cnt_en));
    step(1'b0, 1'b1, 1'b0, 1'b1, "ll_after");
    chk("ll_no_ack2", 32'(o_src_ack), 32'd0);

    i_pll_locked = 1'b1;
    repeat (18) tick();
    chk("relock_trst_hi", 32'(o_timing_rst), 32'd1);
    tick();
    chk("relock_trst_lo", 32'(o_timing_rst), 32'd0);
    step(1'b1, 1'b1, 1'b0, 1'b0, "rl_f1");
    step(1'b1, 1'b1, 1'b1, 1'b0, "rl_f2");
    chk("rl_run", 32'(o_state), 32'd2);
    step(1'b0, 1'b1, 1'b1, 1'b0, "rl_latch");
    step(1'b1, 1'b1, 1'b0, 1'b0, "rl_sw");
    chk("rl_sw_state", 32'(o_state), 32'd3);
    step(1'b1, 1'b1, 1'b1, 1'b0, "rl_end");
    chk("rl_ack",   32'(o_src_ack), 32'd1);
    chk("rl_state", 32'(o_state), 32'd2);
    i_src_req = 1'b0;

    // ---------------- counter saturation ----------------
    for (int k = 0; k < 300; k++) begin
      i_pll_locked = 1'b1;
      repeat (19) tick();
      i_pll_locked = 1'b0;
      repeat (3) tick();
    end
    chk("sat_state", 32'(o_state), 32'd0);
    chk("sat_cnt",   32'(o_lock_lost_cnt), c_cnt_en ? 32'd255 : 32'd0);

    // ---------------- reset mid-operation ----------------
    i_pll_locked = 1'b1;
    repeat (19) tick();
    chk("mid_warm", 32'(o_state), 32'd1);
    i_rst = 1'b1;
    tick();
    chk("mid_rst_state", 32'(o_state), 32'd0);
    chk("mid_rst_trst",  32'(o_timing_rst), 32'd1);
    chk("mid_rst_sel",   32'(o_src_sel), 32'd0);
    chk("mid_rst_cnt",   32'(o_lock_lost_cnt), 32'd0);
    i_rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dvi_output_seq.md
# dvi_output_seq

Bring-up and source-switch sequencer for the DVI output path. It sits between the pixel PLL, the display timing generator, the test-card sources and the TMDS encoder. It holds the timing generator in reset until the PLL lock is stable, then blanks video for a warm-up period. It arbitrates glitch-free source changes at frame boundaries using a req/ack handshake, and gates and registers the RGB/sync stream fed to the encoder.

## Interface
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronised-lock cycles required before timing reset is released.
- `WARMUP_FRAMES`, 2: frame starts counted, with video blanked, after reset release.
- `BLANK_FRAMES`, 1: blanked frames inserted on a source change (≥1).
- `SRC_W`, 2: source-select width.
- `DEFAULT_SRC`, 0: source selected out of reset.
- `H_POL`, 0 and `V_POL`, 0: sync polarities; the inactive level is the complement.

Ports:
- `i_pix_clk`  in  1  pixel clock; the only clock.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_pll_locked`  in  1  raw PLL lock; asynchronous, synchronised internally.
- `i_frame`  in  1  one-cycle frame-start pulse from the timing generator.
- `i_hs`, `i_vs`, `i_de`  in  1 each  timing generator outputs.
- `i_red`, `i_green`, `i_blue`  in  8 each  pixel from the active source.
- `i_src_req`  in  1  source change request (level).
- `i_src_sel`  in  SRC_W  requested source.
- `o_src_ack`  out  1  one-cycle pulse; the requested source is live.
- `o_src_sel`  out  SRC_W  source mux select.
- `o_timing_rst`  out  1  reset to the timing generator.
- `o_video_en`  out  1  video unblanked.
- `o_hs`, `o_vs`, `o_de`  out  1 each  registered syncs to the encoder.
- `o_red`, `o_green`, `o_blue`  out  8 each  registered, gated pixel.
- `o_state`  out  3  current FSM state encoding.
- `o_lock_lost_cnt`  out  8  saturating count of lock-loss events.

## Operation
- `i_pll_locked` passes through a 2-flop synchroniser; `lock_s` is its output.

FSM states:
- **HOLD**:
  - `o_timing_rst=1`.
  - Stable counter increments while `lock_s=1` and clears on `lock_s=0`.
  - At count `LOCK_STABLE_CYCLES`, go to WARMUP.
- **WARMUP**:
  - `o_timing_rst=0`, video blanked.
  - Counts `i_frame` pulses.
  - On the `WARMUP_FRAMES`-th pulse, go to RUN.
- **RUN**:
  - Video enabled.
  - If `i_src_req=1` and no request is pending, latch `i_src_sel` into `pending` and set the `pend` flag.
  - On the next `i_frame` with `pend` set: `o_src_sel<=pending`, go to SWITCH, video blanked.
- **SWITCH**:
  - Counts `i_frame` pulses.
  - On the `BLANK_FRAMES`-th pulse: go to RUN, pulse `o_src_ack`, clear `pend`.

Handshake and lock loss:
- The requester holds `i_src_req` until it sees `o_src_ack`.
- A request seen outside RUN waits; it is sampled on RUN entry.
- If `lock_s=0` in any state other than HOLD: go to HOLD next cycle, clear `pend`, and increment `o_lock_lost_cnt`, saturating at 255.
- Lock loss on the same cycle as an ack-generating frame pulse: lock loss wins and no ack is issued. The requester still holds `i_src_req`, so the request is re-sampled later.
- `i_rst` mid-operation returns the FSM to HOLD with all reset values. `o_lock_lost_cnt` also clears.

Pixel path:
- Enable is the next-state video enable, so gating changes exactly on the frame-start pixel.
- `o_red`, `o_green` and `o_blue` are driven as `(en & i_de) ? i_* : 0`.
- `o_hs`, `o_vs` and `o_de` are `i_*` delayed 1 cycle.
- While `o_timing_rst=1`, syncs are forced to their inactive level and `o_de` to 0.

## Timing
- Reset values:
  - FSM state: HOLD.
  - `o_timing_rst=1`, `o_video_en=0`, `o_src_ack=0`.
  - `o_src_sel=DEFAULT_SRC`.
  - `o_hs=~H_POL`, `o_vs=~V_POL`.
  - `o_de=0`, RGB=0, `o_lock_lost_cnt=0`.
- Lock-release latency: `o_timing_rst` falls 2 + `LOCK_STABLE_CYCLES` + 1 cycles after `i_pll_locked` rises, provided lock stays high.
- Pixel and sync latency: 1 cycle, all outputs registered.
- First unblanked pixel is the one presented with the `WARMUP_FRAMES`-th `i_frame`.
- Source change:
  - `o_src_sel` changes on the frame-start edge.
  - `o_src_ack` asserts on the cycle following the `BLANK_FRAMES`-th subsequent `i_frame`.
- Lock-loss reaction: `o_timing_rst=1` 3 cycles after `i_pll_locked` falls (2 synchroniser cycles plus 1).

## Configuration
- `DVI_SEQ_LOCK_CNT_EN` defined: the lock-loss counter is built and behaves as above.
- `DVI_SEQ_LOCK_CNT_EN` undefined: no counter logic is built and `o_lock_lost_cnt` is tied to 0.
- All other behaviour is identical in both builds.

## Structure
- Package `dvi_seq_pkg` holds:
  - the state enum (HOLD=0, WARMUP=1, RUN=2, SWITCH=3), defining the `o_state` encoding;
  - the default `SRC_W`;
  - the lock counter width.
- One sub-module, `sync_2ff`, provides the lock synchroniser.
- Frame and stable counters stay inline.

## Test plan
- **Bring-up:** lock rises at cycle 10 with `LOCK_STABLE_CYCLES=16` → `o_timing_rst` falls at cycle 29. With `WARMUP_FRAMES=2`, RGB=0 until the 2nd `i_frame`, then the first pixel equals the input.
- **Lock glitch in HOLD:** lock drops for 1 cycle at count 10 → stable counter restarts; `o_lock_lost_cnt` stays 0.
- **Source switch:** in RUN, `i_src_req=1`, `i_src_sel=2` mid-frame → `o_src_sel=2` at the next `i_frame` with RGB=0 for 1 frame; `o_src_ack` pulses once after the next `i_frame`; RUN resumes.
- **Lock loss during SWITCH, coinciding with the ack frame** → no ack, state HOLD, count=1. After re-lock and warm-up, the held request completes with ack.
- **Saturation:** 300 lock-loss events → `o_lock_lost_cnt=255`. With the macro undefined, it reads 0.
- **Sync polarity:** `H_POL=1`, `V_POL=1` under reset → `o_hs=0`, `o_vs=0`, `o_de=0`, RGB=0.
